// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues one word fetch at a time, buffers returned {pc, instr}
// pairs in a small FIFO and hands them to decode; redirects flush everything.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          pending;
    logic          drop;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          pop;
    logic          accept;
    logic          resp_fire;
    logic          wr_en;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_aligned;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign id_valid  = !reset && !redirect_valid && (count != '0);
    assign pop       = id_valid && id_ready;
    assign resp_fire = imem_resp_valid && pending;
    assign wr_en     = resp_fire && !drop && !redirect_valid && !reset;

    // Entries that will be (or may be) occupied once the outstanding fetch lands.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending} - {{CW{1'b0}}, pop};

    assign imem_req_valid = !reset && !redirect_valid && (!pending || imem_resp_valid)
                            && (occupancy < DEPTH_C);
    assign accept         = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = fetch_pc;

    assign id_instr    = instr_mem[rd_ptr];
    assign id_pc       = pc_mem[rd_ptr];
    assign id_pc_plus4 = id_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            pending  <= 1'b0;
            drop     <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            // A response arriving now is simply discarded; otherwise mark it stale.
            if (pending) begin
                pending <= !imem_resp_valid;
                drop    <= !imem_resp_valid;
            end
        end else begin
            if (accept) begin
                pending  <= 1'b1;
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end else if (resp_fire) begin
                pending <= 1'b0;
            end
            if (resp_fire) begin
                drop <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CW'(1);
            end else if (!wr_en && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_resp_data;
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(wr_en && !pop && ({1'b0, count} == DEPTH_C)));

endmodule
